// File: rtl/ascii_hex_pkg.sv
// Shared constants and types for the ASCII hex parsing blocks.
package ascii_hex_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  typedef enum logic {
    ACCUM,
    EMIT
  } parser_state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_TERM,
    CLS_INVALID
  } char_cls_t;

endpackage

// File: rtl/ascii_nibble_decode.sv
// Combinational ASCII character classifier: hex digit value, terminator or invalid.
module ascii_nibble_decode
  import ascii_hex_pkg::*;
#(
  parameter bit         ALLOW_LOWER = 1'b1,
  parameter logic [7:0] DELIM       = 8'h0A
) (
  input  logic [7:0] in_char,
  output logic [3:0] nib,
  output char_cls_t  cls
);

  always_comb begin
    nib = 4'd0;
    cls = CLS_INVALID;
    if (in_char >= CH_0 && in_char <= CH_9) begin
      nib = 4'(in_char - CH_0);
      cls = CLS_DIGIT;
    end else if (in_char >= CH_A_UP && in_char <= CH_F_UP) begin
      nib = 4'(in_char - CH_A_UP + 8'd10);
      cls = CLS_DIGIT;
    end else if (ALLOW_LOWER && in_char >= CH_A_LO && in_char <= CH_F_LO) begin
      nib = 4'(in_char - CH_A_LO + 8'd10);
      cls = CLS_DIGIT;
    end else if (in_char == DELIM || in_char == CH_SP || in_char == CH_CR) begin
      cls = CLS_TERM;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex-to-word parser with valid/ready on both sides.
module ascii_hex_parser
  import ascii_hex_pkg::*;
#(
  parameter int unsigned NIBBLES     = 8,
  parameter bit          ALLOW_LOWER = 1'b1,
  parameter logic [7:0]  DELIM       = 8'h0A,
  localparam int unsigned DATA_W     = 4 * NIBBLES,
  localparam int unsigned CNT_W      = $clog2(NIBBLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  parser_state_t     state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_err_q, out_err_d;

  logic [3:0]        nib;
  char_cls_t         cls;
  logic [DATA_W-1:0] acc_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic [CNT_W-1:0]  emit_count;
  logic              emit_err;

  ascii_nibble_decode #(
    .ALLOW_LOWER(ALLOW_LOWER),
    .DELIM      (DELIM)
  ) u_decode (
    .in_char(in_char),
    .nib    (nib),
    .cls    (cls)
  );

  // Out_valid is high exactly while in EMIT, so it doubles as the input stall.
  assign in_ready  = ~out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    emit        = 1'b0;
    emit_data   = '0;
    emit_count  = '0;
    emit_err    = 1'b0;
    acc_shift   = (acc_q << 4) | DATA_W'(nib);
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          case (cls)
            CLS_DIGIT: begin
              if (cnt_inc == CNT_W'(NIBBLES)) begin
                emit       = 1'b1;
                emit_data  = acc_shift;
                emit_count = cnt_inc;
                emit_err   = err_q;
              end else begin
                acc_d = acc_shift;
                cnt_d = cnt_inc;
              end
            end
            // A bare terminator only produces a word if there is something to report.
            CLS_TERM: begin
              if (cnt_q != '0 || err_q) begin
                emit       = 1'b1;
                emit_data  = acc_q;
                emit_count = cnt_q;
                emit_err   = err_q;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_count_d = emit_count;
      out_err_d   = emit_err;
      acc_d       = '0;
      cnt_d       = '0;
      err_d       = 1'b0;
      state_d     = EMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule
